if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It drives a variable-latency instruction memory through a request/grant/response handshake and buffers fetched words with their PCs in a DEPTH-entry FIFO. It presents them to ID under a valid/ready handshake and redirects on branch_i by flushing the queue and discarding any in-flight response. It sits between pc generation/branch resolution and the ID stage, and replaces the single-register IF.

---
 rtl/if_prefetch_pkg.sv | 26 ++
 rtl/if_prefetch_if.sv | 38 +++
 rtl/if_prefetch_fifo.sv | 83 ++++++++
 rtl/if_prefetch.sv | 128 ++++++++++++
 tb/tb_if_prefetch.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_pkg.sv
`default_nettype none
//==============================================================================
// Module   : if_prefetch_pkg
// Brief    : Shared widths, fetch-FSM encoding and instruction step for the
//            prefetching instruction-fetch stage.
// Revision : 1.0 - initial release
//==============================================================================
package if_prefetch_pkg;

   // Default address / instruction widths
   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   // Byte distance between consecutive instructions
   localparam int INST_STEP     = 4;

   // Fetch FSM: RUN = idle, WAIT = response will be kept,
   // DROP = response belongs to a pre-redirect request and is thrown away
   typedef enum logic [1:0] {
      IF_RUN  = 2'd0,
      IF_WAIT = 2'd1,
      IF_DROP = 2'd2
   } if_state_e;

endpackage : if_prefetch_pkg
`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
//==============================================================================
// Module   : if_prefetch_if
// Brief    : Memory request/grant/response bus plus the valid/ready
//            instruction bus toward ID, bundled for the fetch stage.
// Revision : 1.0 - initial release
//==============================================================================
interface if_prefetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   // Instruction memory side
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [INST_W-1:0] mem_rdata;

   // ID side
   logic              inst_valid;
   logic              inst_ready;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] inst;

   // Fetch stage view
   modport master (
      output mem_req, mem_addr, inst_valid, pc, inst,
      input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
   );

   // Memory + ID view (the environment around the fetch stage)
   modport slave (
      input  mem_req, mem_addr, inst_valid, pc, inst,
      output mem_gnt, mem_rvalid, mem_rdata, inst_ready
   );

endinterface : if_prefetch_if
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
//==============================================================================
// Module   : if_prefetch_fifo
// Brief    : Pointer-wrapped prefetch FIFO. Head is read straight out of the
//            registered storage so a word pushed in cycle N is visible at the
//            head in cycle N+1. Flush has priority over push and pop.
// Revision : 1.0 - initial release
//==============================================================================
module if_prefetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       push_i,
   input  wire logic                       pop_i,
   input  wire logic                       flush_i,
   input  wire logic [WIDTH-1:0]           data_i,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [$clog2(DEPTH):0]          count_o,
   output logic [WIDTH-1:0]                head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic do_pop;
   logic do_push;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == C_DEPTH);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves the same cycle
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage write; cleared on reset so the head reads zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule : if_prefetch_fifo
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
//==============================================================================
// Module   : if_prefetch
// Brief    : Instruction-fetch stage with a DEPTH-entry prefetch queue. Keeps
//            at most one memory request outstanding, buffers {pc, inst} pairs
//            and hands them to ID under valid/ready. A branch flushes the
//            queue and turns an in-flight request into one to be discarded.
// Revision : 1.0 - initial release
//==============================================================================
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int              ADDR_W   = INST_ADDR_BUS,
   parameter int              INST_W   = INST_BUS,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              branch_i,
   input  wire logic [ADDR_W-1:0] branch_target_i,
   if_prefetch_if.master          bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   C_DEPTH_EXT = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] C_DEPTH_M1  = CNT_W'(DEPTH - 1);

   // Registered state
   if_state_e         state_q,    state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] req_pc_q,   req_pc_d;

   // FIFO hookup
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CNT_W-1:0]         fifo_count;
   logic [ADDR_W+INST_W-1:0] fifo_head;
   logic                     push;
   logic                     pop;

   // Handshake terms
   logic [CNT_W:0] occupancy;
   logic           room;
   logic           req;
   logic           grant;
   logic           in_run;
   logic           in_wait;
   logic           in_drop;

   assign in_run  = (state_q == IF_RUN);
   assign in_wait = (state_q == IF_WAIT);
   assign in_drop = (state_q == IF_DROP);

   // Entries held plus the slot reserved for a response we intend to keep
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_wait};
   assign room      = (occupancy < C_DEPTH_EXT);

   // A new request may go out back-to-back with the response that retires
   // the current one; in WAIT that response still needs its own slot.
   assign req = rst_n && !branch_i &&
                ((in_run  && room) ||
                 (in_wait && bus.mem_rvalid && (fifo_count < C_DEPTH_M1)) ||
                 (in_drop && bus.mem_rvalid));

   assign grant = req && bus.mem_gnt;

   assign push = in_wait && bus.mem_rvalid && !branch_i && (!fifo_full || pop);
   assign pop  = bus.inst_valid && bus.inst_ready;

   assign bus.mem_req    = req;
   assign bus.mem_addr   = fetch_pc_q;
   assign bus.inst_valid = !fifo_empty && !branch_i;
   assign bus.pc         = fifo_head[INST_W +: ADDR_W];
   assign bus.inst       = fifo_head[INST_W-1:0];

   // Next-state: redirect beats grant beats plain response retirement
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (branch_i) begin
         fetch_pc_d = branch_target_i;
         if (bus.mem_rvalid) begin
            state_d = IF_RUN;
         end else if (in_wait) begin
            state_d = IF_DROP;
         end
      end else if (grant) begin
         req_pc_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + ADDR_W'(INST_STEP);
         state_d    = IF_WAIT;
      end else if (bus.mem_rvalid && !in_run) begin
         state_d = IF_RUN;
      end
   end

   // FSM and fetch address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IF_RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   if_prefetch_fifo #(
      .WIDTH (ADDR_W + INST_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (branch_i),
      .data_i  ({req_pc_q, bus.mem_rdata}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

endmodule : if_prefetch
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_if_prefetch
// Brief    : Directed, table-driven bench for if_prefetch (DEPTH=4).
// Revision : 1.0 - initial release
//==============================================================================
module tb_if_prefetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        branch;
   logic [31:0] target;

   if_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

   if_prefetch #(
      .ADDR_W   (32),
      .INST_W   (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .branch_i        (branch),
      .branch_target_i (target),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          br;
      logic [31:0] tgt;
      bit          gnt;
      bit          rv;
      logic [31:0] rd;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_val;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic check_out(input int idx, input bit e_req, input logic [31:0] e_addr,
                            input bit e_val, input logic [31:0] e_pc, input logic [31:0] e_inst);
      chk("mem_req", idx, 32'(bus.mem_req), 32'(e_req));
      chk("mem_addr", idx, bus.mem_addr, e_addr);
      chk("inst_valid", idx, 32'(bus.inst_valid), 32'(e_val));
      if (e_val) begin
         chk("pc", idx, bus.pc, e_pc);
         chk("inst", idx, bus.inst, e_inst);
      end
   endtask

   task automatic add(input bit rst, input bit br, input logic [31:0] tgt, input bit gnt,
                      input bit rv, input logic [31:0] rd, input bit rdy, input bit e_req,
                      input logic [31:0] e_addr, input bit e_val, input logic [31:0] e_pc,
                      input logic [31:0] e_inst);
      vec_t v;
      v.rst = rst; v.br = br; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_inst = e_inst;
      vecs.push_back(v);
   endtask

   task automatic drive(input bit br, input logic [31:0] tgt, input bit gnt, input bit rv,
                        input logic [31:0] rd, input bit rdy);
      branch         = br;
      target         = tgt;
      bus.mem_gnt    = gnt;
      bus.mem_rvalid = rv;
      bus.mem_rdata  = rd;
      bus.inst_ready = rdy;
   endtask

   // Reset for two edges, release on a falling edge; caller is then in cycle 0
   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t v;
      drive(0, 0, 0, 0, 0, 0);

      // Inst word for pc p is p ^ 32'hA5A50000 throughout.
      // A: 1-cycle memory, ID ready
      add(1,0,0,1,0,32'h0,1,          1,32'h0, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50000,1,   1,32'h4, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50004,1,   1,32'h8, 1,32'h0,32'hA5A50000);
      add(0,0,0,1,1,32'hA5A50008,1,   1,32'hC, 1,32'h4,32'hA5A50004);
      add(0,0,0,1,1,32'hA5A5000C,1,   1,32'h10,1,32'h8,32'hA5A50008);
      // B: ID stalled until queue fills, then drains and fetch resumes at 0x10
      add(1,0,0,1,0,32'h0,0,          1,32'h0, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50000,0,   1,32'h4, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50004,0,   1,32'h8, 1,32'h0,32'hA5A50000);
      add(0,0,0,1,1,32'hA5A50008,0,   1,32'hC, 1,32'h0,32'hA5A50000);
      add(0,0,0,1,1,32'hA5A5000C,0,   0,32'h10,1,32'h0,32'hA5A50000);
      add(0,0,0,1,0,32'h0,0,          0,32'h10,1,32'h0,32'hA5A50000);
      add(0,0,0,1,0,32'h0,1,          0,32'h10,1,32'h0,32'hA5A50000);
      add(0,0,0,1,0,32'h0,1,          1,32'h10,1,32'h4,32'hA5A50004);
      add(0,0,0,1,1,32'hA5A50010,1,   1,32'h14,1,32'h8,32'hA5A50008);
      add(0,0,0,1,1,32'hA5A50014,1,   1,32'h18,1,32'hC,32'hA5A5000C);
      add(0,0,0,1,1,32'hA5A50018,1,   1,32'h1C,1,32'h10,32'hA5A50010);
      // C: slow memory, branch to 0x100 while WAIT, stale response dropped
      add(1,0,0,1,0,32'h0,1,          1,32'h0, 0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          0,32'h4, 0,32'h0,0);
      add(0,1,32'h100,1,0,32'h0,1,    0,32'h4, 0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          0,32'h100,0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50000,1,   1,32'h100,0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          0,32'h104,0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50100,1,   1,32'h104,0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          0,32'h108,1,32'h100,32'hA5A50100);
      // D: branch coincides with pop and push at 2 entries
      add(1,0,0,1,0,32'h0,0,          1,32'h0, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50000,0,   1,32'h4, 0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50004,0,   1,32'h8, 1,32'h0,32'hA5A50000);
      add(0,1,32'h200,1,1,32'hA5A50008,1, 0,32'hC,0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          1,32'h200,0,32'h0,0);
      add(0,0,0,1,1,32'hA5A50200,1,   1,32'h204,0,32'h0,0);
      add(0,0,0,1,0,32'h0,1,          0,32'h208,1,32'h200,32'hA5A50200);
      // E: grant withheld 5 cycles at 0xFFFFFFFC, then wrap to 0
      add(1,1,32'hFFFFFFFC,0,0,32'h0,0, 0,32'h0,0,32'h0,0);
      for (int k = 0; k < 5; k++) begin
         add(0,0,0,0,0,32'h0,0,       1,32'hFFFFFFFC,0,32'h0,0);
      end
      add(0,0,0,1,0,32'h0,0,          1,32'hFFFFFFFC,0,32'h0,0);
      add(0,0,0,0,0,32'h0,0,          0,32'h0, 0,32'h0,0);
      add(0,0,0,0,1,32'h5A5AFFFC,0,   1,32'h0, 0,32'h0,0);
      add(0,0,0,0,0,32'h0,1,          1,32'h0, 1,32'hFFFFFFFC,32'h5A5AFFFC);

      // Reset-state check with reset asserted
      #1 rst_n = 1'b0;
      #1 check_out(-1, 0, 32'h0, 0, 32'h0, 32'h0);
      chk("reset_pc", -1, bus.pc, 32'h0);
      chk("reset_inst", -1, bus.inst, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.rst) do_reset();
         drive(v.br, v.tgt, v.gnt, v.rv, v.rd, v.rdy);
         #1;
         check_out(i, v.e_req, v.e_addr, v.e_val, v.e_pc, v.e_inst);
         @(posedge clk);
         @(negedge clk);
      end

      // F: asynchronous reset while WAIT with 2 entries queued
      do_reset();
      drive(0, 0, 1, 0, 32'h0, 0);            @(posedge clk); @(negedge clk);
      drive(0, 0, 1, 1, 32'hA5A50000, 0);     @(posedge clk); @(negedge clk);
      drive(0, 0, 1, 1, 32'hA5A50004, 0);     @(posedge clk); @(negedge clk);
      drive(0, 0, 1, 0, 32'h0, 0);
      #1 check_out(100, 0, 32'hC, 1, 32'h0, 32'hA5A50000);
      #1 rst_n = 1'b0;
      #1 check_out(101, 0, 32'h0, 0, 32'h0, 32'h0);
      chk("arst_pc", 101, bus.pc, 32'h0);
      chk("arst_inst", 101, bus.inst, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 32'hA5A50008, 1);
      #1 check_out(102, 1, 32'h0, 0, 32'h0, 32'h0);
      @(posedge clk); @(negedge clk);
      drive(0, 0, 1, 0, 32'h0, 1);
      #1 check_out(103, 1, 32'h0, 0, 32'h0, 32'h0);
      @(posedge clk); @(negedge clk);
      drive(0, 0, 0, 1, 32'hA5A50000, 1);
      #1 check_out(104, 1, 32'h4, 0, 32'h0, 32'h0);
      @(posedge clk); @(negedge clk);
      drive(0, 0, 0, 0, 32'h0, 1);
      #1 check_out(105, 1, 32'h4, 1, 32'h0, 32'hA5A50000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_if_prefetch
`default_nettype wire
